// File: rtl/go_clock_ctrl.sv
// go_clock_ctrl: two-player Go game clock with main time followed by Japanese byoyomi periods.
module go_clock_ctrl #(
    parameter int unsigned MAIN_TIME   = 600,
    parameter int unsigned BYO_TIME    = 30,
    parameter int unsigned BYO_PERIODS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sec_src,
    input  logic        start,
    input  logic        move_done,
    input  logic        pause,
    input  logic        resume,
    output logic [11:0] time_black,
    output logic [11:0] time_white,
    output logic [3:0]  periods_black,
    output logic [3:0]  periods_white,
    output logic        byo_black,
    output logic        byo_white,
    output logic        active,
    output logic        running,
    output logic        paused,
    output logic        timeout,
    output logic        loser,
    output logic        beep_en
);

    localparam int unsigned TW         = 12;
    localparam int unsigned PW         = 4;
    localparam int unsigned BEEP_LIMIT = 10;

    localparam logic [TW-1:0] MAIN_INIT = TW'(MAIN_TIME);
    localparam logic [TW-1:0] BYO_INIT  = TW'(BYO_TIME);
    localparam logic [PW-1:0] PER_INIT  = PW'(BYO_PERIODS);
    localparam logic [TW-1:0] BEEP_MAX  = TW'(BEEP_LIMIT);
    localparam logic [TW-1:0] ONE_SEC   = TW'(1);
    localparam logic [PW-1:0] ONE_PER   = PW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Per-player counters, index 0 = black, 1 = white.
    logic [1:0][TW-1:0] tm_q,  tm_d;
    logic [1:0][PW-1:0] per_q, per_d;
    logic [1:0]         byo_q, byo_d;
    logic               active_q,  active_d;
    logic               loser_q,   loser_d;
    logic               running_q, running_d;
    logic               paused_q,  paused_d;
    logic               timeout_q, timeout_d;
    logic               beep_q,    beep_d;

    // sec_src synchroniser and edge-detect history.
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sec_prev_q, sec_prev_d;
    logic tick_c;

    // Working signals of the game logic.
    logic mover;
    logic timed_out;

    // Two-flop synchroniser followed by one history flop for rising-edge detection.
    always_comb begin
        sync1_d    = sec_src;
        sync2_d    = sync1_q;
        sec_prev_d = sync2_q;
    end

    assign tick_c = sync2_q & ~sec_prev_q;

    // Synchroniser registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sec_prev_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sec_prev_q <= sec_prev_d;
        end
    end

    // Next-state and counter logic: tick on the mover first, then move hand-over, then pause.
    always_comb begin
        state_d   = state_q;
        tm_d      = tm_q;
        per_d     = per_q;
        byo_d     = byo_q;
        active_d  = active_q;
        loser_d   = loser_q;
        mover     = active_q;
        timed_out = 1'b0;

        case (state_q)
            IDLE, TIMEOUT: begin
                if (start) begin
                    tm_d     = {MAIN_INIT, MAIN_INIT};
                    per_d    = {PER_INIT, PER_INIT};
                    byo_d    = 2'b00;
                    active_d = 1'b0;
                    loser_d  = 1'b0;
                    state_d  = RUN;
                end
            end

            RUN: begin
                if (tick_c) begin
                    if (tm_q[mover] > ONE_SEC) begin
                        tm_d[mover] = tm_q[mover] - ONE_SEC;
                    end else if (!byo_q[mover]) begin
                        // Main time exhausted: enter byoyomi, or lose if there is none.
                        if (BYO_PERIODS == 0) begin
                            tm_d[mover] = '0;
                            timed_out   = 1'b1;
                        end else begin
                            tm_d[mover]  = BYO_INIT;
                            byo_d[mover] = 1'b1;
                        end
                    end else if (per_q[mover] == ONE_PER) begin
                        per_d[mover] = '0;
                        tm_d[mover]  = '0;
                        timed_out    = 1'b1;
                    end else begin
                        per_d[mover] = per_q[mover] - ONE_PER;
                        tm_d[mover]  = BYO_INIT;
                    end
                end

                if (timed_out) begin
                    state_d = TIMEOUT;
                    loser_d = mover;
                end else begin
                    if (move_done) begin
                        // A completed move in byoyomi restores the full period.
                        if (byo_d[mover]) begin
                            tm_d[mover] = BYO_INIT;
                        end
                        active_d = ~mover;
                    end
                    if (pause) begin
                        state_d = PAUSED;
                    end
                end
            end

            PAUSED: begin
                if (resume) begin
                    state_d = RUN;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status flags follow the next state so every output changes on the same edge.
    always_comb begin
        running_d = (state_d == RUN);
        paused_d  = (state_d == PAUSED);
        timeout_d = (state_d == TIMEOUT);
        beep_d    = (state_d == RUN) && byo_d[active_d] && (tm_d[active_d] <= BEEP_MAX);
    end

    // Game state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tm_q      <= {MAIN_INIT, MAIN_INIT};
            per_q     <= {PER_INIT, PER_INIT};
            byo_q     <= 2'b00;
            active_q  <= 1'b0;
            loser_q   <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            timeout_q <= 1'b0;
            beep_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tm_q      <= tm_d;
            per_q     <= per_d;
            byo_q     <= byo_d;
            active_q  <= active_d;
            loser_q   <= loser_d;
            running_q <= running_d;
            paused_q  <= paused_d;
            timeout_q <= timeout_d;
            beep_q    <= beep_d;
        end
    end

    assign time_black    = tm_q[0];
    assign time_white    = tm_q[1];
    assign periods_black = per_q[0];
    assign periods_white = per_q[1];
    assign byo_black     = byo_q[0];
    assign byo_white     = byo_q[1];
    assign active        = active_q;
    assign running       = running_q;
    assign paused        = paused_q;
    assign timeout       = timeout_q;
    assign loser         = loser_q;
    assign beep_en       = beep_q;

endmodule

// File: tb/tb_go_clock_ctrl.sv
// tb_go_clock_ctrl: three parameterisations of the game clock checked every cycle against a rule-level model.
module tb_go_clock_ctrl;

    localparam int NI     = 3;
    localparam int P_MAIN = 3;
    localparam int BYO_A  = 2;
    localparam int BYO_B  = 12;
    localparam int BYO_C  = 2;
    localparam int PER_A  = 2;
    localparam int PER_B  = 2;
    localparam int PER_C  = 0;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_PAU  = 2;
    localparam int S_TO   = 3;

    int p_byo [NI] = '{BYO_A, BYO_B, BYO_C};
    int p_per [NI] = '{PER_A, PER_B, PER_C};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sec_src = 1'b0;
    logic start = 1'b0;
    logic move_done = 1'b0;
    logic pause = 1'b0;
    logic resume = 1'b0;

    logic [11:0] tb_o [NI];
    logic [11:0] tw_o [NI];
    logic [3:0]  pb_o [NI];
    logic [3:0]  pw_o [NI];
    logic bb_o [NI];
    logic bw_o [NI];
    logic act_o [NI];
    logic run_o [NI];
    logic pau_o [NI];
    logic to_o [NI];
    logic los_o [NI];
    logic bp_o [NI];

    // Rule-level model state per instance.
    int m_st  [NI];
    int m_tm  [NI][2];
    int m_per [NI][2];
    bit m_byo [NI][2];
    int m_act [NI];
    int m_los [NI];

    int edge_n = 0;
    int due    = -1;
    int n_vec  = 0;
    int n_miss = 0;
    bit cmp_tk;

    always #5 clk = ~clk;

    go_clock_ctrl #(.MAIN_TIME(P_MAIN), .BYO_TIME(BYO_A), .BYO_PERIODS(PER_A)) u_a (
        .clk(clk), .rst_n(rst_n), .sec_src(sec_src), .start(start), .move_done(move_done),
        .pause(pause), .resume(resume), .time_black(tb_o[0]), .time_white(tw_o[0]),
        .periods_black(pb_o[0]), .periods_white(pw_o[0]), .byo_black(bb_o[0]), .byo_white(bw_o[0]),
        .active(act_o[0]), .running(run_o[0]), .paused(pau_o[0]), .timeout(to_o[0]),
        .loser(los_o[0]), .beep_en(bp_o[0]));

    go_clock_ctrl #(.MAIN_TIME(P_MAIN), .BYO_TIME(BYO_B), .BYO_PERIODS(PER_B)) u_b (
        .clk(clk), .rst_n(rst_n), .sec_src(sec_src), .start(start), .move_done(move_done),
        .pause(pause), .resume(resume), .time_black(tb_o[1]), .time_white(tw_o[1]),
        .periods_black(pb_o[1]), .periods_white(pw_o[1]), .byo_black(bb_o[1]), .byo_white(bw_o[1]),
        .active(act_o[1]), .running(run_o[1]), .paused(pau_o[1]), .timeout(to_o[1]),
        .loser(los_o[1]), .beep_en(bp_o[1]));

    go_clock_ctrl #(.MAIN_TIME(P_MAIN), .BYO_TIME(BYO_C), .BYO_PERIODS(PER_C)) u_c (
        .clk(clk), .rst_n(rst_n), .sec_src(sec_src), .start(start), .move_done(move_done),
        .pause(pause), .resume(resume), .time_black(tb_o[2]), .time_white(tw_o[2]),
        .periods_black(pb_o[2]), .periods_white(pw_o[2]), .byo_black(bb_o[2]), .byo_white(bw_o[2]),
        .active(act_o[2]), .running(run_o[2]), .paused(pau_o[2]), .timeout(to_o[2]),
        .loser(los_o[2]), .beep_en(bp_o[2]));

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] dut_vec(input int k);
        return {tb_o[k], tw_o[k], pb_o[k], pw_o[k], bb_o[k], bw_o[k],
                act_o[k], run_o[k], pau_o[k], to_o[k], los_o[k], bp_o[k]};
    endfunction

    function automatic logic [39:0] exp_vec(input int k);
        logic run, beep;
        int a;
        a    = m_act[k];
        run  = (m_st[k] == S_RUN);
        beep = run && m_byo[k][a] && (m_tm[k][a] <= 10);
        return {12'(m_tm[k][0]), 12'(m_tm[k][1]), 4'(m_per[k][0]), 4'(m_per[k][1]),
                m_byo[k][0], m_byo[k][1], 1'(m_act[k]), run, m_st[k] == S_PAU,
                m_st[k] == S_TO, 1'(m_los[k]), beep};
    endfunction

    function automatic logic [39:0] rst_vec(input int k);
        return {12'(P_MAIN), 12'(P_MAIN), 4'(p_per[k]), 4'(p_per[k]), 8'h00};
    endfunction

    task automatic model_load(input int k);
        for (int p = 0; p < 2; p++) begin
            m_tm[k][p]  = P_MAIN;
            m_per[k][p] = p_per[k];
            m_byo[k][p] = 1'b0;
        end
        m_act[k] = 0;
        m_los[k] = 0;
    endtask

    task automatic model_reset_all();
        for (int k = 0; k < NI; k++) begin
            model_load(k);
            m_st[k] = S_IDLE;
        end
    endtask

    // Game rules applied to one instance at one clock edge.
    task automatic model_edge(input int k, input bit tk);
        int a;
        bit out;
        a   = m_act[k];
        out = 1'b0;
        case (m_st[k])
            S_IDLE, S_TO: begin
                if (start) begin
                    model_load(k);
                    m_st[k] = S_RUN;
                end
            end
            S_RUN: begin
                if (tk) begin
                    if (m_tm[k][a] > 1) begin
                        m_tm[k][a]--;
                    end else if (!m_byo[k][a]) begin
                        if (p_per[k] == 0) begin
                            m_tm[k][a] = 0;
                            out = 1'b1;
                        end else begin
                            m_tm[k][a]  = p_byo[k];
                            m_byo[k][a] = 1'b1;
                        end
                    end else if (m_per[k][a] == 1) begin
                        m_per[k][a] = 0;
                        m_tm[k][a]  = 0;
                        out = 1'b1;
                    end else begin
                        m_per[k][a]--;
                        m_tm[k][a] = p_byo[k];
                    end
                end
                if (out) begin
                    m_st[k]  = S_TO;
                    m_los[k] = a;
                end else begin
                    if (move_done) begin
                        if (m_byo[k][a]) m_tm[k][a] = p_byo[k];
                        m_act[k] = 1 - a;
                    end
                    if (pause) m_st[k] = S_PAU;
                end
            end
            S_PAU: begin
                if (resume) m_st[k] = S_RUN;
            end
            default: ;
        endcase
    endtask

    // Model update at each edge, then comparison of every output just after it.
    always @(posedge clk) begin
        edge_n++;
        cmp_tk = (edge_n == due);
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) model_reset_all();
            else model_edge(k, cmp_tk);
        end
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("cycle%0d_dut%0d", edge_n, k), dut_vec(k), exp_vec(k));
        end
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input bit st, input bit mv, input bit ps, input bit rs);
        start = st; move_done = mv; pause = ps; resume = rs;
        nxt();
        start = 0; move_done = 0; pause = 0; resume = 0;
    endtask

    // One sec_src period; the tick lands on the third edge, optionally with a move.
    task automatic tick(input bit mv);
        sec_src = 1'b1;
        due = edge_n + 3;
        nxt();
        nxt();
        sec_src = 1'b0;
        move_done = mv;
        nxt();
        move_done = 1'b0;
        nxt();
    endtask

    task automatic async_reset_check(input string tag);
        rst_n = 1'b0;
        sec_src = 1'b0;
        due = -1;
        model_reset_all();
        #1;
        for (int k = 0; k < NI; k++) chk($sformatf("%s_rst%0d", tag, k), dut_vec(k), rst_vec(k));
    endtask

    initial begin : drive
        int sec_left;
        model_reset_all();
        repeat (3) nxt();
        for (int k = 0; k < NI; k++) chk($sformatf("por_rst%0d", k), dut_vec(k), rst_vec(k));
        rst_n = 1'b1;
        nxt();
        nxt();

        // Main time runs down, then black enters byoyomi.
        pulse(1, 0, 0, 0);
        chk("start_running", 40'(run_o[0]), 40'd1);
        tick(0);
        tick(0);
        chk("two_ticks_tb", 40'(tb_o[0]), 40'd1);
        chk("two_ticks_tw", 40'(tw_o[0]), 40'd3);
        tick(0);
        chk("enter_byo_tb", 40'(tb_o[0]), 40'd2);
        chk("enter_byo_flag", 40'(bb_o[0]), 40'd1);
        chk("enter_byo_per", 40'(pb_o[0]), 40'd2);
        chk("no_byo_timeout", {28'd0, tb_o[2]}, 40'd0);
        chk("no_byo_to_flag", 40'(to_o[2]), 40'd1);
        chk("beep_off_at12", 40'(bp_o[1]), 40'd0);

        // Byoyomi periods exhausted without a move.
        tick(0);
        chk("beep_off_at11", 40'(bp_o[1]), 40'd0);
        tick(0);
        chk("beep_on_at10", 40'(bp_o[1]), 40'd1);
        chk("per_dec_1", 40'(pb_o[0]), 40'd1);
        tick(0);
        tick(0);
        chk("timeout_flag", 40'(to_o[0]), 40'd1);
        chk("timeout_loser", 40'(los_o[0]), 40'd0);
        chk("timeout_per", 40'(pb_o[0]), 40'd0);
        tick(0);
        chk("frozen_vec", dut_vec(0), {12'd0, 12'd3, 4'd0, 4'd2, 8'b1000_0100});

        // Move in byoyomi, then tick coinciding with a move.
        pulse(1, 0, 0, 0);
        repeat (4) tick(0);
        chk("byo_at1_tb", 40'(tb_o[0]), 40'd1);
        pulse(0, 1, 0, 0);
        chk("move_active", 40'(act_o[0]), 40'd1);
        chk("move_reload", 40'(tb_o[0]), 40'd2);
        tick(1);
        chk("tick_move_tw", 40'(tw_o[0]), 40'd2);
        chk("tick_move_act", 40'(act_o[0]), 40'd0);

        // Pause holds the counters; resume keeps the active player.
        pulse(0, 0, 1, 0);
        chk("paused_flag", 40'(pau_o[0]), 40'd1);
        repeat (5) tick(0);
        chk("paused_vec", dut_vec(0), {12'd2, 12'd2, 4'd2, 4'd2, 8'b1000_1000});
        pulse(0, 0, 0, 1);
        chk("resume_run", 40'(run_o[0]), 40'd1);
        chk("resume_act", 40'(act_o[0]), 40'd0);
        pulse(0, 1, 1, 0);
        chk("move_pause_act", 40'(act_o[0]), 40'd1);
        chk("move_pause_flag", 40'(pau_o[0]), 40'd1);
        pulse(0, 0, 0, 1);
        chk("resume2_act", 40'(act_o[0]), 40'd1);

        // Tick latency: the count changes on the third edge only.
        sec_src = 1'b1;
        due = edge_n + 3;
        nxt();
        chk("lat_edge1", 40'(tw_o[0]), 40'd2);
        nxt();
        chk("lat_edge2", 40'(tw_o[0]), 40'd2);
        sec_src = 1'b0;
        nxt();
        chk("lat_edge3", 40'(tw_o[0]), 40'd1);
        nxt();
        pulse(1, 0, 0, 0);
        chk("start_ignored", 40'(tw_o[0]), 40'd1);

        // Reset in the middle of a game.
        #3;
        async_reset_check("mid");
        nxt();
        nxt();
        rst_n = 1'b1;
        nxt();
        nxt();
        chk("post_rst_idle", 40'(run_o[0]), 40'd0);

        // Randomised play.
        sec_left = 2;
        pulse(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset_check("rnd");
                nxt();
                rst_n = 1'b1;
                sec_left = 2;
                nxt();
                continue;
            end
            sec_left--;
            if (sec_left == 0) begin
                if (sec_src == 1'b0) begin
                    sec_src = 1'b1;
                    due = edge_n + 3;
                    sec_left = int'($urandom_range(2, 4));
                end else begin
                    sec_src = 1'b0;
                    sec_left = int'($urandom_range(2, 6));
                end
            end
            start     = ($urandom_range(0, 59) == 0);
            move_done = ($urandom_range(0, 3) == 0);
            pause     = ($urandom_range(0, 24) == 0);
            resume    = ($urandom_range(0, 5) == 0);
            nxt();
        end
        start = 0; move_done = 0; pause = 0; resume = 0;
        nxt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
